// File: rtl/memtest_pll_sweep.sv
// Steps a PLL through a ROM-held frequency table over its reconfiguration port,
// retries on lock timeout, and keeps minute/second counters for the memory test.
module memtest_pll_sweep #(
  parameter int NUM_ENTRIES = 38,
  parameter int IDX_W       = 6,
  parameter int CLK_HZ      = 50000000,
  parameter int GAP_CYC     = 8,
  parameter int LOCK_TMO    = 1000000,
  parameter int MAX_RETRY   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_up,
  input  logic             cmd_down,
  input  logic             cmd_retest,
  input  logic             cmd_auto,
  input  logic             step_ok,
  output logic [IDX_W-1:0] rom_idx,
  input  logic [31:0]      rom_m,
  input  logic [31:0]      rom_k,
  input  logic [31:0]      rom_c,
  output logic [5:0]       mgmt_address,
  output logic [31:0]      mgmt_writedata,
  output logic             mgmt_write,
  input  logic             mgmt_waitrequest,
  input  logic             pll_locked,
  output logic             pll_reset,
  output logic             busy,
  output logic             auto_mode,
  output logic             sweep_done,
  output logic             error,
  output logic [15:0]      elapsed_bcd,
  output logic [2:0]       sec_cnt
);

  localparam longint unsigned MIN_CYC = 64'd60 * 64'(CLK_HZ);
  localparam int SEC_W = $clog2(CLK_HZ + 1);
  localparam int MIN_W = $clog2(MIN_CYC + 1);
  localparam int TMO_W = $clog2(LOCK_TMO + 1);
  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_ENTRIES - 1);

  typedef enum logic [2:0] {IDLE, WR, GAP, PRST, WLOCK, ERR} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] pos_q, pos_d;
  logic             auto_q, auto_d, done_q, done_d, err_q;
  logic [2:0]       wr_idx_q, tbl_idx;
  logic             mw_q, restart_q, pll_rst_q, prst_q;
  logic [5:0]       addr_q, wr_addr;
  logic [31:0]      data_q, wr_data;
  logic [GAP_W-1:0] gap_q;
  logic [TMO_W-1:0] tmo_q;
  logic [RTY_W-1:0] retry_q;
  logic             cmd_acc;

  logic [SEC_W-1:0] sec_presc_q;
  logic [MIN_W-1:0] min_presc_q;
  logic [2:0]       sec_q;
  logic [15:0]      elapsed_q;

  // Leaving GAP preloads the next write, so the table is indexed one ahead there.
  assign tbl_idx = wr_idx_q + 3'(state_q == GAP);

  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    case (tbl_idx)
      3'd0: begin wr_addr = 6'd0; wr_data = '0;           end
      3'd1: begin wr_addr = 6'd4; wr_data = rom_m;        end
      3'd2: begin wr_addr = 6'd7; wr_data = rom_k;        end
      3'd3: begin wr_addr = 6'd3; wr_data = 32'h0001_0000; end
      3'd4: begin wr_addr = 6'd5; wr_data = rom_c;        end
      3'd5: begin wr_addr = 6'd9; wr_data = 32'd1;        end
      3'd6: begin wr_addr = 6'd8; wr_data = 32'd7;        end
      default: begin wr_addr = 6'd2; wr_data = '0;        end
    endcase
  end

  always_comb begin
    cmd_acc = 1'b0;
    pos_d   = pos_q;
    auto_d  = auto_q;
    done_d  = done_q;
    if (cmd_auto) begin
      cmd_acc = 1'b1;
      pos_d   = '0;
      auto_d  = 1'b1;
      done_d  = 1'b0;
    end else if (cmd_retest) begin
      cmd_acc = 1'b1;
      auto_d  = 1'b0;
    end else if (cmd_up) begin
      if (pos_q < LAST) begin
        cmd_acc = 1'b1;
        pos_d   = pos_q + 1'b1;
        auto_d  = 1'b0;
      end
    end else if (cmd_down) begin
      if (pos_q != '0) begin
        cmd_acc = 1'b1;
        pos_d   = pos_q - 1'b1;
        auto_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= WR;
      pos_q     <= '0;
      auto_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_idx_q  <= '0;
      mw_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      pll_rst_q <= 1'b0;
      prst_q    <= 1'b0;
      gap_q     <= '0;
      tmo_q     <= '0;
      retry_q   <= '0;
      restart_q <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      auto_q <= auto_d;
      done_q <= done_d;
      if (cmd_acc) begin
        err_q     <= 1'b0;
        pll_rst_q <= 1'b0;
        retry_q   <= '0;
      end
      // A pending handshake must complete first; the WR branch then restarts.
      if (cmd_acc && !(state_q == WR && mw_q)) begin
        state_q   <= WR;
        wr_idx_q  <= '0;
        restart_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (auto_q && step_ok) begin
              if (pos_q < LAST) begin
                pos_q    <= pos_q + 1'b1;
                state_q  <= WR;
                wr_idx_q <= '0;
              end else begin
                auto_q <= 1'b0;
                done_q <= 1'b1;
              end
            end
          end
          WR: begin
            if (!mw_q) begin
              mw_q   <= 1'b1;
              addr_q <= wr_addr;
              data_q <= wr_data;
            end else if (!mgmt_waitrequest) begin
              mw_q <= 1'b0;
              if (cmd_acc || restart_q) begin
                restart_q <= 1'b0;
                wr_idx_q  <= '0;
              end else begin
                state_q <= GAP;
                gap_q   <= '0;
              end
            end else if (cmd_acc) begin
              restart_q <= 1'b1;
            end
          end
          GAP: begin
            if (gap_q == GAP_W'(GAP_CYC - 1)) begin
              if (wr_idx_q == 3'd7) begin
                state_q   <= PRST;
                pll_rst_q <= 1'b1;
                prst_q    <= 1'b0;
              end else begin
                state_q  <= WR;
                wr_idx_q <= wr_idx_q + 3'd1;
                mw_q     <= 1'b1;
                addr_q   <= wr_addr;
                data_q   <= wr_data;
              end
            end else begin
              gap_q <= gap_q + 1'b1;
            end
          end
          PRST: begin
            if (prst_q) begin
              pll_rst_q <= 1'b0;
              state_q   <= WLOCK;
              tmo_q     <= '0;
            end else begin
              prst_q <= 1'b1;
            end
          end
          WLOCK: begin
            if (pll_locked) begin
              state_q <= IDLE;
              retry_q <= '0;
            end else if (tmo_q == TMO_W'(LOCK_TMO - 1)) begin
              if (retry_q == RTY_W'(MAX_RETRY - 1)) begin
                state_q <= ERR;
                err_q   <= 1'b1;
                retry_q <= '0;
              end else begin
                retry_q  <= retry_q + 1'b1;
                state_q  <= WR;
                wr_idx_q <= '0;
              end
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end
          ERR: ;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sec_presc_q <= '0;
      sec_q       <= '0;
      min_presc_q <= '0;
      elapsed_q   <= '0;
    end else begin
      if (sec_presc_q == SEC_W'(CLK_HZ - 1)) begin
        sec_presc_q <= '0;
        sec_q       <= sec_q + 3'd1;
      end else begin
        sec_presc_q <= sec_presc_q + 1'b1;
      end
      if (busy) begin
        min_presc_q <= '0;
        elapsed_q   <= '0;
      end else if (min_presc_q == MIN_W'(MIN_CYC - 1)) begin
        min_presc_q <= '0;
        elapsed_q   <= bcd_inc(elapsed_q);
      end else begin
        min_presc_q <= min_presc_q + 1'b1;
      end
    end
  end

  assign busy           = (state_q != IDLE) && (state_q != ERR);
  assign rom_idx        = pos_q;
  assign mgmt_address   = addr_q;
  assign mgmt_writedata = data_q;
  assign mgmt_write     = mw_q;
  assign pll_reset      = pll_rst_q;
  assign auto_mode      = auto_q;
  assign sweep_done     = done_q;
  assign error          = err_q;
  assign elapsed_bcd    = elapsed_q;
  assign sec_cnt        = sec_q;

endmodule

// File: doc/memtest_pll_sweep.md
MEMTEST_PLL_SWEEP -- requirements
Module: memtest_pll_sweep

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 38: number of frequency table entries.
REQ-002 SHALL have parameter IDX_W, default 6: width of the table index (2**IDX_W >= NUM_ENTRIES).
REQ-003 SHALL have parameter CLK_HZ, default 50000000: clk frequency for the elapsed-time prescaler.
REQ-004 SHALL have parameter GAP_CYC, default 8: idle cycles after each accepted mgmt write (>=1).
REQ-005 SHALL have parameter LOCK_TMO, default 1000000: cycles to wait for lock before a retry.
REQ-006 SHALL have parameter MAX_RETRY, default 3: reconfiguration attempts per entry before an error.
REQ-007 SHALL have ports, one clock domain, asynchronous active-high reset (name  direction  width  meaning):
 clk  in  1  sole clock
 reset  in  1  asynchronous, active-high
 cmd_up / cmd_down / cmd_retest / cmd_auto  in  1 each  single-cycle command pulses
 step_ok  in  1  level: test at the current entry is judged complete
 rom_idx  out  IDX_W  table index presented to the external ROM
 rom_m / rom_k / rom_c  in  32 each  M, K, C0 words for rom_idx, valid 1 cycle after rom_idx changes
 mgmt_address  out  6  PLL reconfig register address
 mgmt_writedata  out  32  PLL reconfig write data
 mgmt_write  out  1  write request
 mgmt_waitrequest  in  1  reconfig slave stall
 pll_locked  in  1  PLL lock, already synchronised to clk
 pll_reset  out  1  PLL reset
 busy  out  1  reconfiguration in progress (downstream memory tester held in reset)
 auto_mode  out  1  automatic sweep active
 sweep_done  out  1  auto sweep reached the last entry
 error  out  1  lock not obtained after MAX_RETRY attempts
 elapsed_bcd  out  16  minutes since last reconfig, 4 BCD digits
 sec_cnt  out  3  free-running seconds modulo 8

Function
REQ-008 SHALL use states IDLE, WR, GAP, PRST, WLOCK, ERR.
REQ-009 SHALL drive rom_idx equal to the registered position pos at all times.
REQ-010 SHALL issue, in WR order: (0,0), (4,rom_m), (7,rom_k), (3,0x10000), (5,rom_c), (9,1), (8,7), (2,0) as (address,data).
REQ-011 SHALL hold mgmt_write, mgmt_address and mgmt_writedata stable until a cycle with mgmt_waitrequest=0; that cycle is the acceptance, after which mgmt_write deasserts next cycle.
REQ-012 SHALL wait GAP_CYC cycles in GAP after each acceptance, then enter WR for the next write, or PRST after write 8.
REQ-013 SHALL assert pll_reset for exactly 2 cycles in PRST, then enter WLOCK.
REQ-014 SHALL, in WLOCK, return to IDLE on the first cycle pll_locked=1 and clear the retry count.
REQ-015 SHALL, in WLOCK, restart at write 1 on a LOCK_TMO cycle timeout and increment retries; after MAX_RETRY failed attempts it SHALL enter ERR and set error.
REQ-016 SHALL hold ERR until any command pulse; that pulse clears error and restarts the sequence.
REQ-017 SHALL assert busy in every state except IDLE and ERR.
REQ-018 SHALL apply commands at the same priority in any state: cmd_auto (pos<=0, auto_mode<=1, sweep_done<=0) > cmd_retest (auto_mode<=0) > cmd_up (pos+1 if pos<NUM_ENTRIES-1, auto_mode<=0) > cmd_down (pos-1 if pos>0, auto_mode<=0).
REQ-019 SHALL ignore cmd_up at pos=NUM_ENTRIES-1 and cmd_down at pos=0 entirely, with no restart.
REQ-020 SHALL, on any accepted command mid-sequence, abort the current write after its acceptance (never mid-handshake), deassert pll_reset, and restart at write 1 one cycle later so the ROM data matches the new pos.
REQ-021 SHALL, when auto_mode=1, state IDLE and step_ok=1: if pos<NUM_ENTRIES-1, increment pos and start a sequence; otherwise clear auto_mode and set sweep_done.
REQ-022 SHALL clear the prescalers and elapsed_bcd while busy=1.
REQ-023 SHALL increment elapsed_bcd by 1 every 60*CLK_HZ idle cycles, BCD carry per digit, wrapping 9999->0000.
REQ-024 SHALL increment sec_cnt every CLK_HZ cycles regardless of busy, wrapping 7->0.

Reset
REQ-025 SHALL, on reset, asynchronously set pos=0, auto_mode=1, busy=1, start at write 1 with mgmt_write=0, and hold pll_reset=0, error=0, sweep_done=0, elapsed_bcd=0, sec_cnt=0 and retries=0.
REQ-026 SHALL start the reset-initiated sequence on the first clk edge after reset deasserts.

Verification
REQ-027 SHALL show that after reset with waitrequest=0 and GAP_CYC=8 the eight writes appear at 9-cycle spacing, followed by a 2-cycle pll_reset, and that lock drops busy to 0.
REQ-028 SHALL show that waitrequest held high for 5 cycles on write 2 leaves address 4 and data rom_m stable for 6 cycles, with no lost or duplicate write.
REQ-029 SHALL show that with NUM_ENTRIES=4, auto_mode and step_ok=1, pos steps 0->1->2->3, then sweep_done=1 and auto_mode=0.
REQ-030 SHALL show that with pos=0, cmd_down produces no sequence, and cmd_up during write 3 restarts at write 1 with pos=1 and auto_mode=0.
REQ-031 SHALL show that with LOCK_TMO=100, MAX_RETRY=3 and pll_locked=0, there are 3 full sequences, then error=1 and busy=0; cmd_retest then clears error.
REQ-032 SHALL show that with CLK_HZ=10 and 600 idle cycles, elapsed_bcd=0x0001; a forced 9999 wraps to 0000; asserting busy clears it.
